cube_redraw_ctrl: RTL and testbench

//   Sequencer for the cube rendering datapath on the 160x120, 9-bit-colour VGA path.

---
 rtl/cube_gfx_pkg.sv | 25 ++
 rtl/pixel_pass_counter.sv | 32 +++
 rtl/cube_redraw_ctrl.sv | 108 ++++++++++
 tb/tb_cube_redraw_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cube_gfx_pkg.sv
// Shared constants and types for the cube rendering datapath on the 160x120 VGA path.
package cube_gfx_pkg;

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned STICKER_PIX = 64;
  localparam int unsigned NUM_STICKERS = 54;
  localparam int unsigned IDX_W       = 15;

  localparam int unsigned DEFAULT_CLEAR_PIXELS = SCREEN_W * SCREEN_H;
  localparam int unsigned DEFAULT_CUBE_PIXELS  = NUM_STICKERS * STICKER_PIX;

  localparam logic [1:0] PASS_NONE  = 2'd0;
  localparam logic [1:0] PASS_CLEAR = 2'd1;
  localparam logic [1:0] PASS_CUBE  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_CUBE  = 3'd3,
    ST_DONE  = 3'd4
  } redraw_state_t;

endpackage

// File: rtl/pixel_pass_counter.sv
// Pixel index counter for one pass; wraps to zero on the last accepted index so the
// next pass (or the idle state) starts from idx 0 without an extra cycle.
module pixel_pass_counter #(
  parameter int unsigned W       = 15,
  parameter int unsigned LIMIT_A = 19200,
  parameter int unsigned LIMIT_B = 3456
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         adv,
  input  logic         sel_b,
  output logic [W-1:0] count,
  output logic         last_c
);

  localparam logic [W-1:0] LAST_A = W'(LIMIT_A - 1);
  localparam logic [W-1:0] LAST_B = W'(LIMIT_B - 1);

  assign last_c = (count == (sel_b ? LAST_B : LAST_A));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (adv) begin
      count <= last_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/cube_redraw_ctrl.sv
// Redraw sequencer: coalesces redraw requests into snapshot, optional clear pass and cube pass.
module cube_redraw_ctrl
  import cube_gfx_pkg::*;
#(
  parameter int unsigned CLEAR_PIXELS = DEFAULT_CLEAR_PIXELS,
  parameter int unsigned CUBE_PIXELS  = DEFAULT_CUBE_PIXELS,
  parameter int unsigned CLEAR_EVERY  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             redraw_req,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [1:0]       pass,
  output logic [IDX_W-1:0] idx,
  output logic             snapshot,
  output logic             busy,
  output logic             done
);

  redraw_state_t state;
  logic          pending;
  logic          first_frame;
  logic          accept_c;
  logic          last_c;

  assign accept_c = pix_valid && pix_ready;

  pixel_pass_counter #(
    .W       (IDX_W),
    .LIMIT_A (CLEAR_PIXELS),
    .LIMIT_B (CUBE_PIXELS)
  ) u_counter (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state == ST_IDLE),
    .adv    (accept_c),
    .sel_b  (state == ST_CUBE),
    .count  (idx),
    .last_c (last_c)
  );

  // Reset leaves pending set so the first full frame starts on its own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      pending     <= 1'b1;
      first_frame <= 1'b1;
      pix_valid   <= 1'b0;
      pass        <= PASS_NONE;
      snapshot    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (redraw_req) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pending || redraw_req) begin
            state    <= ST_SNAP;
            pending  <= 1'b0;
            snapshot <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SNAP: begin
          snapshot  <= 1'b0;
          pix_valid <= 1'b1;
          if ((CLEAR_EVERY != 0) || first_frame) begin
            state <= ST_CLEAR;
            pass  <= PASS_CLEAR;
          end else begin
            state <= ST_CUBE;
            pass  <= PASS_CUBE;
          end
        end
        ST_CLEAR: begin
          if (accept_c && last_c) begin
            state <= ST_CUBE;
            pass  <= PASS_CUBE;
          end
        end
        ST_CUBE: begin
          if (accept_c && last_c) begin
            state     <= ST_DONE;
            pix_valid <= 1'b0;
            pass      <= PASS_NONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_DONE: begin
          done        <= 1'b0;
          first_frame <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          pix_valid <= 1'b0;
          pass      <= PASS_NONE;
          snapshot  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cube_redraw_ctrl.sv
// Bench for cube_redraw_ctrl: three parameterisations checked every cycle against a
// frame-level model that tracks pixels remaining per pass.
module tb_cube_redraw_ctrl;

  localparam int NC_A = 19200, NU_A = 3456; localparam bit CE_A = 1'b1;
  localparam int NC_B = 40,    NU_B = 3456; localparam bit CE_B = 1'b0;
  localparam int NC_C = 64,    NU_C = 1200; localparam bit CE_C = 1'b1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic req_a = 0, rdy_a = 1, req_b = 0, rdy_b = 1, req_c = 0, rdy_c = 1;

  logic valid_a, snap_a, busy_a, done_a; logic [1:0] pass_a; logic [14:0] idx_a;
  logic valid_b, snap_b, busy_b, done_b; logic [1:0] pass_b; logic [14:0] idx_b;
  logic valid_c, snap_c, busy_c, done_c; logic [1:0] pass_c; logic [14:0] idx_c;

  always #5 clk = ~clk;

  cube_redraw_ctrl dut_a (
    .clk(clk), .resetn(resetn), .redraw_req(req_a), .pix_ready(rdy_a),
    .pix_valid(valid_a), .pass(pass_a), .idx(idx_a), .snapshot(snap_a),
    .busy(busy_a), .done(done_a));

  cube_redraw_ctrl #(.CLEAR_PIXELS(NC_B), .CUBE_PIXELS(NU_B), .CLEAR_EVERY(0)) dut_b (
    .clk(clk), .resetn(resetn), .redraw_req(req_b), .pix_ready(rdy_b),
    .pix_valid(valid_b), .pass(pass_b), .idx(idx_b), .snapshot(snap_b),
    .busy(busy_b), .done(done_b));

  cube_redraw_ctrl #(.CLEAR_PIXELS(NC_C), .CUBE_PIXELS(NU_C), .CLEAR_EVERY(1)) dut_c (
    .clk(clk), .resetn(resetn), .redraw_req(req_c), .pix_ready(rdy_c),
    .pix_valid(valid_c), .pass(pass_c), .idx(idx_c), .snapshot(snap_c),
    .busy(busy_c), .done(done_c));

  // Frame-level model: a frame is a snapshot, then clear_left + cube_left pixels, then done.
  typedef struct {
    int clear_left;
    int cube_left;
    bit snap;
    bit done;
    bit pending;
    bit first;
  } mdl_t;

  mdl_t m_a, m_b, m_c;
  int checks = 0;
  int failures = 0;
  int snap_cnt_c = 0, done_cnt_c = 0;
  int last_cube_idx_b = -1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.clear_left = 0; m.cube_left = 0; m.snap = 0; m.done = 0; m.pending = 1; m.first = 1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int nc, int nu, bit ce, bit req, bit rdy);
    mdl_t n = m;
    bit active = (m.clear_left > 0) || (m.cube_left > 0);
    if (m.snap) begin
      n.snap = 0;
      n.clear_left = (ce || m.first) ? nc : 0;
      n.cube_left = nu;
      if (req) n.pending = 1;
    end else if (active) begin
      if (rdy) begin
        if (m.clear_left > 0) n.clear_left = m.clear_left - 1;
        else n.cube_left = m.cube_left - 1;
      end
      if (n.clear_left == 0 && n.cube_left == 0) n.done = 1;
      if (req) n.pending = 1;
    end else if (m.done) begin
      n.done = 0;
      n.first = 0;
      if (req) n.pending = 1;
    end else if (m.pending || req) begin
      n.snap = 1;
      n.pending = 0;
    end
    return n;
  endfunction

  function automatic logic [20:0] exp_pack(mdl_t m, int nc, int nu);
    logic v;
    logic [1:0] p;
    logic [14:0] ix;
    v = (m.clear_left > 0) || (m.cube_left > 0);
    if (m.clear_left > 0) begin p = 2'd1; ix = 15'(nc - m.clear_left); end
    else if (m.cube_left > 0) begin p = 2'd2; ix = 15'(nu - m.cube_left); end
    else begin p = 2'd0; ix = 15'd0; end
    return {v, p, ix, m.snap, m.snap | v, m.done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_a", 32'({valid_a, pass_a, idx_a, snap_a, busy_a, done_a}), 32'(exp_pack(m_a, NC_A, NU_A)));
    check("out_b", 32'({valid_b, pass_b, idx_b, snap_b, busy_b, done_b}), 32'(exp_pack(m_b, NC_B, NU_B)));
    check("out_c", 32'({valid_c, pass_c, idx_c, snap_c, busy_c, done_c}), 32'(exp_pack(m_c, NC_C, NU_C)));
    check("snap_vs_valid_c", 32'(snap_c & valid_c), 32'd0);
    check("done_vs_busy_a", 32'(done_a & busy_a), 32'd0);
  endtask

  // One clock: inputs were set before the edge, outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!resetn) begin
      m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
    end else begin
      m_a = mdl_step(m_a, NC_A, NU_A, CE_A, req_a, rdy_a);
      m_b = mdl_step(m_b, NC_B, NU_B, CE_B, req_b, rdy_b);
      m_c = mdl_step(m_c, NC_C, NU_C, CE_C, req_c, rdy_c);
    end
    compare_all();
    snap_cnt_c += int'(snap_c);
    done_cnt_c += int'(done_c);
    if (valid_b && pass_b == 2'd2) last_cube_idx_b = int'(idx_b);
  endtask

  initial begin
    int snap_at, done_at, k;
    bit pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

    m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
    #1;
    compare_all();
    tick(); tick();
    resetn = 1'b1;

    // Test 1: automatic first frame on dut_a with pix_ready high.
    snap_at = 0; done_at = 0;
    for (int i = 1; i <= 22700; i++) begin
      tick();
      if (snap_a && snap_at == 0) snap_at = i;
      if (done_a && done_at == 0) done_at = i;
    end
    check("t1_snapshot_cycle", 32'(snap_at), 32'd1);
    check("t1_done_cycle", 32'(done_at), 32'd22658);
    check("t1_idle_after", 32'({busy_a, valid_a, pass_a}), 32'd0);

    // Test 2: dut_b skips the clear pass on its second frame.
    req_b = 1; tick(); req_b = 0;
    k = 1;
    while (!done_b && k < 4000) begin tick(); k++; end
    check("t2_done_reached", 32'(done_b), 32'd1);
    check("t2_done_latency", 32'(k), 32'd3458);

    // Test 4: pix_ready 1,0,0,1 on dut_b's cube pass.
    last_cube_idx_b = -1;
    req_b = 1; tick(); req_b = 0;
    k = 0;
    while (!done_b && k < 9000) begin rdy_b = pat[k % 4]; tick(); k++; end
    rdy_b = 1;
    check("t4_done_reached", 32'(done_b), 32'd1);
    check("t4_final_idx", 32'(last_cube_idx_b), 32'd3455);

    // Test 3: five requests during the cube pass coalesce into one extra frame.
    snap_cnt_c = 0; done_cnt_c = 0;
    req_c = 1; tick(); req_c = 0;
    k = 0;
    while (pass_c != 2'd2 && k < 200) begin tick(); k++; end
    check("t3_in_cube", 32'(pass_c), 32'd2);
    for (int p = 0; p < 5; p++) begin
      req_c = 1; tick(); req_c = 0; tick(); tick(); tick();
    end
    k = 0;
    while (done_cnt_c < 2 && k < 5000) begin tick(); k++; end
    for (int i = 0; i < 20; i++) tick();
    check("t3_done_count", 32'(done_cnt_c), 32'd2);
    check("t3_snapshot_count", 32'(snap_cnt_c), 32'd2);

    // Test 5: request landing exactly in the DONE cycle.
    req_c = 1; tick(); req_c = 0;
    k = 0;
    while (!done_c && k < 2000) begin tick(); k++; end
    check("t5_done_reached", 32'(done_c), 32'd1);
    req_c = 1; tick(); req_c = 0;
    check("t5_idle_gap", 32'({snap_c, busy_c}), 32'd0);
    tick();
    check("t5_snap_after_gap", 32'(snap_c), 32'd1);
    k = 0;
    while (!done_c && k < 2000) begin tick(); k++; end
    check("t5_second_done", 32'(done_c), 32'd1);
    tick();

    // Test 6: asynchronous reset at cube idx 1000 on dut_c.
    req_c = 1; tick(); req_c = 0;
    k = 0;
    while (!(pass_c == 2'd2 && idx_c == 15'd1000) && k < 3000) begin tick(); k++; end
    check("t6_reached_idx", 32'(idx_c), 32'd1000);
    resetn = 1'b0;
    #1;
    m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
    check("t6_async_zero_c", 32'({valid_c, pass_c, idx_c, snap_c, busy_c, done_c}), 32'd0);
    compare_all();
    tick(); tick();
    resetn = 1'b1;
    k = 0;
    while (!valid_c && k < 10) begin tick(); k++; end
    check("t6_restart_clear", 32'({pass_c, idx_c}), 32'({2'd1, 15'd0}));
    check("t6_b_clears_after_reset", 32'(pass_b), 32'd1);
    k = 0;
    while (!done_c && k < 3000) begin tick(); k++; end
    check("t6_frame_done", 32'(done_c), 32'd1);

    // Random traffic on dut_c; dut_b handshake randomised too.
    for (int i = 0; i < 6000; i++) begin
      req_c = ($urandom_range(0, 199) == 0);
      rdy_c = ($urandom_range(0, 3) != 0);
      req_b = ($urandom_range(0, 499) == 0);
      rdy_b = ($urandom_range(0, 1) != 0);
      tick();
    end
    req_c = 0; req_b = 0; rdy_c = 1; rdy_b = 1;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
